// File: rtl/max30102_pkg.sv
// Shared constants, FSM state type and helpers for the MAX30102 FIFO reader.
package max30102_pkg;

    localparam logic [7:0] FIFO_WR_PTR = 8'h04;
    localparam logic [7:0] FIFO_RD_PTR = 8'h06;
    localparam logic [7:0] FIFO_DATA   = 8'h07;

    localparam int unsigned BYTES_PER_SAMPLE = 6;
    localparam int unsigned BYTES_PER_WORD   = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRdWr,
        StRdRd,
        StCalc,
        StRdSmp,
        StEmit,
        StErr
    } state_e;

    // The sensor FIFO is 32 deep; pointers wrap in 5 bits, so equal pointers read as empty.
    function automatic logic [4:0] fifo_count(input logic [4:0] wr_ptr, input logic [4:0] rd_ptr);
        return wr_ptr - rd_ptr;
    endfunction

endpackage

// File: rtl/max30102_fifo_reader_if.sv
// Register-read handshake between the FIFO reader and the shared byte-level I2C master.
interface max30102_fifo_reader_if;

    logic       i2c_start;
    logic [7:0] i2c_reg;
    logic [2:0] i2c_len;
    logic       i2c_busy;
    logic       i2c_rx_valid;
    logic [7:0] i2c_rx_data;
    logic       i2c_done;
    logic       i2c_err;

    modport master (
        output i2c_start,
        output i2c_reg,
        output i2c_len,
        input  i2c_busy,
        input  i2c_rx_valid,
        input  i2c_rx_data,
        input  i2c_done,
        input  i2c_err
    );

    modport slave (
        input  i2c_start,
        input  i2c_reg,
        input  i2c_len,
        output i2c_busy,
        output i2c_rx_valid,
        output i2c_rx_data,
        output i2c_done,
        output i2c_err
    );

endinterface

// File: rtl/ppg_sample_unpack.sv
// Collects the six bytes of one FIFO sample (red then IR, MSB first) into two words
// and counts the bytes received since the last clear.
module ppg_sample_unpack
    import max30102_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] red_word,
    output logic [DATA_WIDTH-1:0] ir_word,
    output logic [2:0]            byte_cnt,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] red_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [2:0]            cnt_q;

    assign full = (cnt_q == 3'(BYTES_PER_SAMPLE));

    // Only the low DATA_WIDTH bits of each 24-bit word are kept: after three byte shifts
    // every older bit has fallen off the top, which is the same as masking the full word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            red_q <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
        end else if (byte_valid && !full) begin
            if (cnt_q < 3'(BYTES_PER_WORD)) begin
                red_q <= DATA_WIDTH'({red_q, byte_data});
            end else begin
                ir_q <= DATA_WIDTH'({ir_q, byte_data});
            end
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign red_word = red_q;
    assign ir_word  = ir_q;
    assign byte_cnt = cnt_q;

endmodule

// File: rtl/max30102_fifo_reader.sv
// Polls the MAX30102 FIFO pointers over the shared I2C master, bursts out each pending
// sample and emits one valid pulse per red/IR pair.
module max30102_fifo_reader
    import max30102_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 18,
    parameter int unsigned POLL_CYCLES    = 500000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    max30102_fifo_reader_if.master i2c,
    output logic                   o_data_valid,
    output logic [DATA_WIDTH-1:0]  o_red_data,
    output logic [DATA_WIDTH-1:0]  o_ir_data,
    output logic [7:0]             o_err_cnt,
    output logic                   o_busy
);

    localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q;
    logic [PW-1:0]         poll_q;
    logic [TW-1:0]         tmo_q;
    logic [4:0]            wr_ptr_q;
    logic [4:0]            rd_ptr_q;
    logic [4:0]            remaining_q;
    logic                  start_q;
    logic [7:0]            reg_q;
    logic [2:0]            len_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] red_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [7:0]            err_cnt_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] unpack_red;
    logic [DATA_WIDTH-1:0] unpack_ir;
    logic [2:0]            unpack_cnt;
    logic                  unpack_full;

    logic                  poll_hit;
    logic                  tmo_hit;
    logic                  enough_bytes;
    logic                  txn_fail;
    logic [4:0]            n_samples;

    // Byte capture restarts with every issued read; start_q is high on each RD_* entry cycle.
    ppg_sample_unpack #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_q),
        .byte_valid(i2c.i2c_rx_valid),
        .byte_data (i2c.i2c_rx_data),
        .red_word  (unpack_red),
        .ir_word   (unpack_ir),
        .byte_cnt  (unpack_cnt),
        .full      (unpack_full)
    );

    assign poll_hit     = (poll_q == PW'(POLL_CYCLES - 1));
    assign tmo_hit      = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign enough_bytes = (state_q == StRdSmp) ? unpack_full : (unpack_cnt != 3'd0);
    assign n_samples    = fifo_count(wr_ptr_q, rd_ptr_q);
    // An error pulse beats a simultaneous done; a short read counts as a failure too.
    assign txn_fail     = i2c.i2c_err || (i2c.i2c_done && !enough_bytes) ||
                          (!i2c.i2c_done && tmo_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            poll_q      <= '0;
            tmo_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            start_q     <= 1'b0;
            reg_q       <= '0;
            len_q       <= '0;
            valid_q     <= 1'b0;
            red_q       <= '0;
            ir_q        <= '0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_enable) begin
                        if (!poll_hit) begin
                            poll_q <= poll_q + PW'(1);
                        end else if (!i2c.i2c_busy) begin
                            poll_q  <= '0;
                            state_q <= StRdWr;
                            busy_q  <= 1'b1;
                            start_q <= 1'b1;
                            reg_q   <= FIFO_WR_PTR;
                            len_q   <= 3'd1;
                            tmo_q   <= '0;
                        end
                    end
                end
                StRdWr, StRdRd, StRdSmp: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (i2c.i2c_rx_valid && state_q == StRdWr) begin
                        wr_ptr_q <= i2c.i2c_rx_data[4:0];
                    end
                    if (i2c.i2c_rx_valid && state_q == StRdRd) begin
                        rd_ptr_q <= i2c.i2c_rx_data[4:0];
                    end
                    if (txn_fail) begin
                        state_q <= StErr;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else if (i2c.i2c_done) begin
                        if (state_q == StRdSmp) begin
                            state_q <= StEmit;
                            valid_q <= 1'b1;
                            red_q   <= unpack_red;
                            ir_q    <= unpack_ir;
                        end else if (!i_enable) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else if (state_q == StRdWr) begin
                            state_q <= StRdRd;
                            start_q <= 1'b1;
                            reg_q   <= FIFO_RD_PTR;
                            len_q   <= 3'd1;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (n_samples == 5'd0 || !i_enable) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        remaining_q <= n_samples;
                        state_q     <= StRdSmp;
                        start_q     <= 1'b1;
                        reg_q       <= FIFO_DATA;
                        len_q       <= 3'(BYTES_PER_SAMPLE);
                        tmo_q       <= '0;
                    end
                end
                StEmit: begin
                    if (remaining_q != 5'd1 && i_enable) begin
                        remaining_q <= remaining_q - 5'd1;
                        state_q     <= StRdSmp;
                        start_q     <= 1'b1;
                        reg_q       <= FIFO_DATA;
                        len_q       <= 3'(BYTES_PER_SAMPLE);
                        tmo_q       <= '0;
                    end else begin
                        remaining_q <= '0;
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                    end
                end
                StErr: begin
                    remaining_q <= '0;
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i2c.i2c_start = start_q;
    assign i2c.i2c_reg   = reg_q;
    assign i2c.i2c_len   = len_q;
    assign o_data_valid  = valid_q;
    assign o_red_data    = red_q;
    assign o_ir_data     = ir_q;
    assign o_err_cnt     = err_cnt_q;
    assign o_busy        = busy_q;

endmodule
